// File: rtl/sum_delay_ctrl_pkg.sv
// Shared types and constants for the sum-delay filter configuration controller.
`timescale 1ns/1ps
package sum_delay_ctrl_pkg;
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    APPLY  = 2'd2,
    WARMUP = 2'd3
  } state_e;

  localparam int DEFAULT_SEL_C = 24;
  localparam int DRAIN_W       = 4;
endpackage

// File: rtl/sum_delay_warmup_cnt.sv
// Saturating count of fresh samples after a delay change; done looks at the next
// count so the controller can leave WARMUP right after the m-th sample.
`timescale 1ns/1ps
module sum_delay_warmup_cnt #(
  parameter int SIZE = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic [SIZE-1:0] target_i,
  output logic            done_o
);
  logic [SIZE:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q < {1'b0, target_i}))
      cnt_d = cnt_q + 1'b1;
  end

  assign done_o = (cnt_d >= {1'b0, target_i});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/sum_delay_ctrl.sv
// Delay-change controller: stalls the stream, reprograms and clears the delay line,
// then masks filter output until the line holds m samples of the new history.
`timescale 1ns/1ps
module sum_delay_ctrl
  import sum_delay_ctrl_pkg::*;
#(
  parameter int SIZE         = 5,
  parameter int TowPowSIZE   = 32,
  parameter int DEFAULT_SEL  = DEFAULT_SEL_C,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic [SIZE-1:0] cfg_tdata,
  input  logic            cfg_tvalid,
  output logic            cfg_tready,
  input  logic            smp_tvalid,
  input  logic            smp_tready,
  output logic            in_allow,
  output logic [SIZE-1:0] dly_sel_data,
  output logic            dly_sel_valid,
  output logic            dly_clear,
  output logic            out_gate,
  output logic [SIZE-1:0] cur_sel,
  output logic            busy
);
  localparam logic [SIZE-1:0]    DEF_SEL_C = SIZE'(DEFAULT_SEL % TowPowSIZE);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  state_e              state_q, state_d;
  logic [SIZE-1:0]     cur_q, cur_d, pend_q, pend_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic                sel_vld_q, dclr_q;
  logic                warm_done;

  sum_delay_warmup_cnt #(.SIZE(SIZE)) u_warm (
    .clk      (clk),
    .rst      (reset),
    .clr_i    (clear || (state_q != WARMUP)),
    .en_i     ((state_q == WARMUP) && smp_tvalid && smp_tready),
    .target_i (cur_q),
    .done_o   (warm_done)
  );

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    pend_d  = pend_q;
    drain_d = drain_q;
    case (state_q)
      RUN: if (cfg_tvalid && (cfg_tdata != cur_q)) begin
        pend_d  = cfg_tdata;
        drain_d = '0;
        state_d = DRAIN;
      end
      DRAIN: if (drain_q == DRAIN_LAST) begin
        cur_d   = pend_q;
        state_d = APPLY;
      end else begin
        drain_d = drain_q + 1'b1;
      end
      APPLY:   state_d = WARMUP;
      default: if (warm_done) state_d = RUN;
    endcase
    // Soft clear wins over everything, including a request arriving this cycle.
    if (clear) begin
      state_d = WARMUP;
      cur_d   = cur_q;
      pend_d  = cur_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= WARMUP;
      cur_q     <= DEF_SEL_C;
      pend_q    <= DEF_SEL_C;
      drain_q   <= '0;
      sel_vld_q <= 1'b0;
      dclr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      pend_q    <= pend_d;
      drain_q   <= drain_d;
      sel_vld_q <= (state_d == APPLY);
      dclr_q    <= (state_d == APPLY) || clear;
    end
  end

  assign cfg_tready    = (state_q == RUN) && !clear;
  assign in_allow      = (state_q == RUN) || (state_q == WARMUP);
  assign out_gate      = (state_q == RUN);
  assign busy          = (state_q != RUN);
  assign cur_sel       = cur_q;
  assign dly_sel_data  = cur_q;
  assign dly_sel_valid = sel_vld_q;
  assign dly_clear     = dclr_q;
endmodule

// File: tb/tb_sum_delay_ctrl.sv
// Bench for sum_delay_ctrl: table of delay requests plus hand sequences for clear,
// held requests and async reset; select pulses are scored against a queue.
`timescale 1ns/1ps
module tb_sum_delay_ctrl;
  localparam int SIZE = 5;
  localparam int DRAIN_CYCLES = 2;
  localparam int DEF = 24;

  logic            clk = 1'b0;
  logic            reset, clear, cfg_tvalid, cfg_tready, smp_tvalid, smp_tready;
  logic            in_allow, dly_sel_valid, dly_clear, out_gate, busy;
  logic [SIZE-1:0] cfg_tdata, dly_sel_data, cur_sel;

  int n_chk = 0, n_pass = 0, pulses = 0, exp_sel;
  int exp_q[$];

  typedef struct {
    int sel;
    int mode;   // 0 continuous samples, 1 half duty, 2 no samples
    int exp_n;
    int exp_cyc;
  } vec_t;
  vec_t vecs[6];

  sum_delay_ctrl #(.SIZE(SIZE), .TowPowSIZE(32), .DEFAULT_SEL(DEF), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .cfg_tdata(cfg_tdata), .cfg_tvalid(cfg_tvalid), .cfg_tready(cfg_tready),
    .smp_tvalid(smp_tvalid), .smp_tready(smp_tready), .in_allow(in_allow),
    .dly_sel_data(dly_sel_data), .dly_sel_valid(dly_sel_valid), .dly_clear(dly_clear),
    .out_gate(out_gate), .cur_sel(cur_sel), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (!reset && dly_sel_valid) begin
      if (exp_q.size() == 0) chk("sel_pulse_expected", exp_q.size(), 1);
      else begin
        chk("sel_pulse_data", int'(dly_sel_data), exp_q.pop_front());
        chk("sel_pulse_clear", int'(dly_clear), 1);
        pulses++;
      end
    end
  end

  task automatic wait_gate(input int mode, output int n, output int cyc);
    n = 0; cyc = 0;
    while (!out_gate && cyc < 200) begin
      smp_tvalid = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'b0;
      if (in_allow && smp_tvalid && smp_tready) n++;
      cyc++;
      @(negedge clk);
    end
    chk("gate_within_bound", int'(cyc < 200), 1);
    smp_tvalid = 1'b1;
  endtask

  task automatic count_stall(output int lows);
    lows = 0;
    while (!in_allow && lows < 20) begin
      lows++;
      @(negedge clk);
    end
  endtask

  task automatic req(input vec_t v);
    int lows, n, c;
    if (v.sel != exp_sel) exp_q.push_back(v.sel);
    cfg_tvalid = 1'b1;
    cfg_tdata  = v.sel[SIZE-1:0];
    chk("req_tready", int'(cfg_tready), 1);
    @(negedge clk);
    cfg_tvalid = 1'b0;
    if (v.sel == exp_sel) begin
      chk("noop_busy", int'(busy), 0);
      chk("noop_in_allow", int'(in_allow), 1);
      chk("noop_out_gate", int'(out_gate), 1);
      chk("noop_no_pulse", int'(dly_sel_valid), 0);
      chk("noop_cur_sel", int'(cur_sel), v.sel);
    end else begin
      count_stall(lows);
      chk("stall_cycles", lows, DRAIN_CYCLES + 1);
      chk("pulse_one_cycle", int'(dly_sel_valid), 0);
      wait_gate(v.mode, n, c);
      chk("warm_samples", n, v.exp_n);
      chk("warm_cycles", c, v.exp_cyc);
      chk("new_cur_sel", int'(cur_sel), v.sel);
      chk("run_busy", int'(busy), 0);
      exp_sel = v.sel;
    end
  endtask

  initial begin
    int n, c, lows;
    vecs[0] = '{8, 0, 8, 8};
    vecs[1] = '{8, 0, 0, 0};
    vecs[2] = '{0, 2, 0, 1};
    vecs[3] = '{16, 1, 16, 32};
    vecs[4] = '{31, 0, 31, 31};
    vecs[5] = '{1, 0, 1, 1};

    reset = 1'b1; clear = 1'b0; cfg_tvalid = 1'b0; cfg_tdata = '0;
    smp_tvalid = 1'b1; smp_tready = 1'b1; exp_sel = DEF;
    @(negedge clk); @(negedge clk);
    chk("rst_in_allow", int'(in_allow), 1);
    chk("rst_out_gate", int'(out_gate), 0);
    chk("rst_cfg_tready", int'(cfg_tready), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_cur_sel", int'(cur_sel), DEF);
    chk("rst_sel_data", int'(dly_sel_data), DEF);
    chk("rst_sel_valid", int'(dly_sel_valid), 0);
    chk("rst_dly_clear", int'(dly_clear), 0);

    reset = 1'b0;
    wait_gate(0, n, c);
    chk("boot_samples", n, DEF);
    chk("boot_busy", int'(busy), 0);
    chk("boot_cfg_tready", int'(cfg_tready), 1);

    for (int i = 0; i < 6; i++) req(vecs[i]);

    // clear after 5 warmup samples restarts the count
    exp_q.push_back(16);
    cfg_tvalid = 1'b1; cfg_tdata = 5'd16;
    @(negedge clk);
    cfg_tvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("clr_warmup_allow", int'(in_allow), 1);
    smp_tvalid = 1'b1;
    repeat (5) @(negedge clk);
    smp_tvalid = 1'b0; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_pulse", int'(dly_clear), 1);
    chk("clr_no_sel", int'(dly_sel_valid), 0);
    chk("clr_busy", int'(busy), 1);
    chk("clr_cur_sel", int'(cur_sel), 16);
    wait_gate(0, n, c);
    chk("clr_samples", n, 16);
    exp_sel = 16;

    // request held high outside RUN is taken on the first RUN cycle
    exp_q.push_back(4);
    cfg_tvalid = 1'b1; cfg_tdata = 5'd4;
    @(negedge clk);
    exp_q.push_back(7);
    cfg_tdata = 5'd7;
    chk("hold_drain_tready", int'(cfg_tready), 0);
    repeat (3) @(negedge clk);
    chk("hold_warm_tready", int'(cfg_tready), 0);
    wait_gate(0, n, c);
    chk("hold_first_samples", n, 4);
    chk("hold_run_tready", int'(cfg_tready), 1);
    @(negedge clk);
    cfg_tvalid = 1'b0;
    chk("hold_taken_busy", int'(busy), 1);
    count_stall(lows);
    chk("hold_stall", lows, DRAIN_CYCLES + 1);
    wait_gate(0, n, c);
    chk("hold_second_samples", n, 7);
    chk("hold_cur_sel", int'(cur_sel), 7);
    exp_sel = 7;

    // clear beats a request in the same cycle
    cfg_tvalid = 1'b1; cfg_tdata = 5'd3; clear = 1'b1;
    #1 chk("prio_tready", int'(cfg_tready), 0);
    @(negedge clk);
    cfg_tvalid = 1'b0; clear = 1'b0;
    chk("prio_cur_sel", int'(cur_sel), 7);
    chk("prio_dly_clear", int'(dly_clear), 1);
    chk("prio_no_sel", int'(dly_sel_valid), 0);
    chk("prio_warmup", int'(in_allow && busy), 1);
    wait_gate(0, n, c);
    chk("prio_samples", n, 7);

    // async reset mid-DRAIN drops the pending select
    cfg_tvalid = 1'b1; cfg_tdata = 5'd12;
    @(negedge clk);
    cfg_tvalid = 1'b0;
    chk("ar_in_drain", int'(in_allow), 0);
    #2 reset = 1'b1; smp_tvalid = 1'b0;
    #1;
    chk("ar_in_allow", int'(in_allow), 1);
    chk("ar_busy", int'(busy), 1);
    chk("ar_out_gate", int'(out_gate), 0);
    chk("ar_cur_sel", int'(cur_sel), DEF);
    chk("ar_sel_valid", int'(dly_sel_valid), 0);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("ar_no_apply", int'(in_allow), 1);
    wait_gate(0, n, c);
    chk("ar_samples", n, DEF);
    chk("ar_cur_after", int'(cur_sel), DEF);

    repeat (4) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    chk("pulse_total", pulses, 8);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
